clk_div_sched: RTL and testbench

- Synchronous clock-enable scheduler that replaces ripple-clocked divider chains with one free-running counter in the `clk` domain.
- Produces a one-cycle `tick` enable and a square-wave `phase` at a selectable ratio of 2^sel.
- Accepts ratio-change requests over a valid/ready handshake and applies them only at a period boundary, so downstream logic never sees a truncated period.
- Sits between the top-level control registers (`ui_in`-driven config) and any logic that needs divided-rate enables.

---
 rtl/clk_div_sched.sv | 116 +++++++++++
 tb/tb_clk_div_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// clk_div_sched: single-counter clock-enable scheduler with boundary-aligned ratio changes.
// Optional registered output y (cnt[0] & cnt[2]) when CLK_DIV_SCHED_Y_EN is defined.
module clk_div_sched #(
    parameter int CNT_W       = 4,
    parameter int DEFAULT_SEL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_sel,
    output logic       cfg_ready,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] cur_sel,
    output logic       tick,
    output logic       phase
`ifdef CLK_DIV_SCHED_Y_EN
    ,
    output logic       y
`endif
);

    localparam logic [3:0] MAX_SEL = 4'(CNT_W);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] mask;
    logic [CNT_W-1:0] msb;
    logic [2:0]       pend_sel;
    logic [2:0]       pend_nxt;
    logic [2:0]       sel_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             bnd;
    logic             sel_ok;

    // mask covers cnt[cur_sel-1:0]; msb isolates its top bit for phase
    always_comb begin
        mask = CNT_W'((32'(1) << cur_sel) - 32'(1));
        msb  = mask & ~(mask >> 1);
    end

    assign bnd       = en && ((cnt & mask) == mask);
    assign tick      = bnd;
    assign phase     = |(cnt & msb);
    assign cfg_ready = (state == IDLE);
    assign sel_ok    = (cfg_sel != 3'd0) && ({1'b0, cfg_sel} <= MAX_SEL);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_sel;
        sel_nxt   = cur_sel;
        cnt_nxt   = en ? cnt + CNT_W'(1) : cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_valid) begin
                    if (sel_ok) begin
                        pend_nxt  = cfg_sel;
                        state_nxt = PEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            PEND: begin
                // switch on the old-ratio boundary; clear restarts the new period
                if (bnd) begin
                    sel_nxt   = pend_sel;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_sel  <= 3'(DEFAULT_SEL);
            pend_sel <= 3'(DEFAULT_SEL);
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur_sel  <= sel_nxt;
            pend_sel <= pend_nxt;
            cfg_done <= done_nxt;
            cfg_err  <= err_nxt;
        end
    end

`ifdef CLK_DIV_SCHED_Y_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= 1'b0;
        end else begin
            y <= cnt[0] & cnt[2];
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed and random stimulus against an arithmetic model of the scheduler.
module tb_clk_div_sched;

    localparam int CNT_W = 4;
    localparam int MODN  = 1 << CNT_W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_sel = 3'd0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic [2:0] cur_sel;
    logic       tick;
    logic       phase;
`ifdef CLK_DIV_SCHED_Y_EN
    logic       y;
`endif

    clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_SEL(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cur_sel   (cur_sel),
        .tick      (tick),
        .phase     (phase)
`ifdef CLK_DIV_SCHED_Y_EN
        ,
        .y         (y)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;

    // model state: counter value, active ratio, pending request, expected pulses
    int m_cnt, m_sel, m_psel;
    bit m_pend, m_done, m_err, m_y;

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sel  = 1;
        m_psel = 1;
        m_pend = 0;
        m_done = 0;
        m_err  = 0;
        m_y    = 0;
    endtask

    function automatic int exp_tick();
        int p = 1 << m_sel;
        return (en && ((m_cnt + 1) % p == 0)) ? 1 : 0;
    endfunction

    function automatic int exp_phase();
        return (m_cnt / (1 << (m_sel - 1))) % 2;
    endfunction

    task automatic model_update();
        bit b;
        b      = (exp_tick() == 1);
        m_y    = ((m_cnt % 2) == 1) && (((m_cnt / 4) % 2) == 1);
        m_done = 0;
        m_err  = 0;
        if (m_pend) begin
            if (b) begin
                m_sel  = m_psel;
                m_cnt  = 0;
                m_pend = 0;
                m_done = 1;
            end else if (en) begin
                m_cnt = (m_cnt + 1) % MODN;
            end
        end else begin
            if (cfg_valid) begin
                if (int'(cfg_sel) >= 1 && int'(cfg_sel) <= CNT_W) begin
                    m_pend = 1;
                    m_psel = int'(cfg_sel);
                end else begin
                    m_err = 1;
                end
            end
            if (en) m_cnt = (m_cnt + 1) % MODN;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input logic [2:0] s);
        @(negedge clk);
        reset     = r;
        en        = e;
        cfg_valid = v;
        cfg_sel   = s;
        if (r) model_reset();
        #1;
        chk("tick", int'(tick), exp_tick());
        chk("phase", int'(phase), exp_phase());
        chk("cfg_ready", int'(cfg_ready), m_pend ? 0 : 1);
        chk("cfg_done", int'(cfg_done), int'(m_done));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        chk("cur_sel", int'(cur_sel), m_sel);
        chk("done_err_excl", int'(cfg_done && cfg_err), 0);
`ifdef CLK_DIV_SCHED_Y_EN
        chk("y", int'(y), int'(m_y));
`endif
        if (cfg_done) done_seen++;
        @(posedge clk);
        if (!r) model_update();
    endtask

    initial begin
        int k;
        model_reset();
        // reset state
        step(1, 1, 0, 3'd0);
        step(1, 1, 0, 3'd0);
        chk("rst_ready_lit", int'(cfg_ready), 1);
        chk("rst_sel_lit", int'(cur_sel), 1);
        chk("rst_done_lit", int'(cfg_done), 0);

        // divide by 2 after release: tick/phase alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 3'd0);
            chk("div2_tick_lit", int'(tick), i % 2);
            chk("div2_phase_lit", int'(phase), i % 2);
        end

        // request ratio 3 at cnt=0: switch at cnt=1, done next cycle
        step(1, 1, 0, 3'd0);
        step(0, 1, 1, 3'd3);
        chk("req_ready_lit", int'(cfg_ready), 1);
        step(0, 1, 0, 3'd0);
        chk("pend_ready_lit", int'(cfg_ready), 0);
        chk("pend_tick_lit", int'(tick), 1);
        step(0, 1, 0, 3'd0);
        chk("sw_done_lit", int'(cfg_done), 1);
        chk("sw_sel_lit", int'(cur_sel), 3);
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, 0, 3'd0);
            chk("div8_tick_lit", int'(tick), (i == 7) ? 1 : 0);
        end

        // illegal requests
        step(0, 1, 1, 3'd0);
        step(0, 1, 1, 3'd5);
        chk("err0_lit", int'(cfg_err), 1);
        chk("err0_ready_lit", int'(cfg_ready), 1);
        step(0, 1, 0, 3'd0);
        chk("err5_lit", int'(cfg_err), 1);
        chk("err_sel_lit", int'(cur_sel), 3);
        step(0, 1, 0, 3'd0);
        chk("err_clear_lit", int'(cfg_err), 0);

        // go to ratio 4, then request 2 while en is low
        step(0, 1, 1, 3'd4);
        k = 0;
        while (m_pend && k < 40) begin
            step(0, 1, 0, 3'd0);
            k++;
        end
        step(0, 1, 0, 3'd0);
        chk("sel4_lit", int'(cur_sel), 4);
        step(0, 0, 1, 3'd2);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 3'd0);
            chk("hold_tick_lit", int'(tick), 0);
            chk("hold_sel_lit", int'(cur_sel), 4);
        end
        for (int i = 0; i < 20; i++) step(0, 1, 0, 3'd0);
        chk("done_once_lit", done_seen, 1);
        chk("sel2_lit", int'(cur_sel), 2);

        // reset while pending
        step(0, 0, 1, 3'd3);
        step(0, 0, 0, 3'd0);
        chk("pend2_ready_lit", int'(cfg_ready), 0);
        step(1, 0, 0, 3'd0);
        chk("rstp_sel_lit", int'(cur_sel), 1);
        chk("rstp_ready_lit", int'(cfg_ready), 1);
        done_seen = 0;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 3'd0);
        chk("rstp_nodone_lit", done_seen, 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0,
                 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
